// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its companions.
// Holds the transmitter state encoding, frame length, parity helper and command bytes.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      START,
      SHIFT,
      ACK,
      WAIT_REL
   } ps2_tx_state_t;

   // Device falling edges in one host-to-device frame, including the ack clock.
   localparam int PS2_FRAME_FALLS = 11;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

   // Odd parity: the returned bit makes the total count of ones in data+parity odd.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_clk_sync.sv
// Three-flop synchroniser for the PS/2 clock and data lines plus a registered
// falling-edge detector on the clock; shared with the ps2_keyboard receiver.
module ps2_clk_sync (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic clk_level,
   output logic data_level,
   output logic fall
);

   logic [2:0] clk_sync;
   logic [2:0] data_sync;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         // Idle lines float high, so presetting to 1 avoids a false fall after reset.
         clk_sync  <= 3'b111;
         data_sync <= 3'b111;
         fall      <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[1:0], ps2_clk};
         data_sync <= {data_sync[1:0], ps2_data};
         fall      <= clk_sync[2] & ~clk_sync[1];
      end
   end

   assign clk_level  = clk_sync[2];
   assign data_level = data_sync[2];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 11-fall frame, ack, release.
// Define PS2_TX_ACK_CHECK_EN to report a missing device acknowledge through err.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       done,
   output logic       err
);

   localparam int INH_W  = $clog2(INHIBIT_CYCLES) + 1;
   localparam int WDOG_W = $clog2(TIMEOUT_CYCLES) + 1;

`ifdef PS2_TX_ACK_CHECK_EN
   localparam logic ACK_CHECK = 1'b1;
`else
   localparam logic ACK_CHECK = 1'b0;
`endif

   logic              clk_level;
   logic              data_level;
   logic              fall;
   ps2_tx_state_t     state;
   logic [7:0]        shreg;
   logic              parity;
   logic [3:0]        bit_cnt;
   logic [INH_W-1:0]  inh_cnt;
   logic [WDOG_W-1:0] wdog;
   logic              ack_ok;

   ps2_clk_sync u_sync (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .clk_level  (clk_level),
      .data_level (data_level),
      .fall       (fall)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         tx_ready    <= 1'b1;
         done        <= 1'b0;
         err         <= 1'b0;
         shreg       <= '0;
         parity      <= 1'b0;
         bit_cnt     <= '0;
         inh_cnt     <= '0;
         wdog        <= '0;
         ack_ok      <= 1'b0;
      end else begin
         // NOTE: done/err default low every cycle so each completion is a single pulse.
         done <= 1'b0;
         err  <= 1'b0;

         case (state)
            IDLE: begin
               if (tx_valid) begin
                  shreg       <= tx_data;
                  parity      <= odd_parity(tx_data);
                  inh_cnt     <= INH_W'(INHIBIT_CYCLES - 1);
                  ps2_clk_oe  <= 1'b1;
                  ps2_data_oe <= 1'b0;
                  tx_ready    <= 1'b0;
                  state       <= INHIBIT;
               end
            end

            INHIBIT: begin
               if (inh_cnt == '0) begin
                  ps2_data_oe <= 1'b1;
                  state       <= START;
               end else begin
                  inh_cnt <= inh_cnt - INH_W'(1);
               end
            end

            START: begin
               // Releasing the clock hands control to the device; data stays low as the start bit.
               ps2_clk_oe <= 1'b0;
               wdog       <= WDOG_W'(TIMEOUT_CYCLES);
               bit_cnt    <= '0;
               state      <= SHIFT;
            end

            SHIFT, ACK, WAIT_REL: begin
               if (!fall && wdog <= WDOG_W'(1)) begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  tx_ready    <= 1'b1;
                  done        <= 1'b1;
                  err         <= 1'b1;
                  state       <= IDLE;
               end else begin
                  if (fall) wdog <= WDOG_W'(TIMEOUT_CYCLES);
                  else      wdog <= wdog - WDOG_W'(1);

                  case (state)
                     SHIFT: begin
                        if (fall) begin
                           bit_cnt <= bit_cnt + 4'd1;
                           if (bit_cnt < 4'd8) begin
                              ps2_data_oe <= ~shreg[0];
                              shreg       <= {1'b0, shreg[7:1]};
                           end else if (bit_cnt == 4'd8) begin
                              ps2_data_oe <= ~parity;
                           end else begin
                              ps2_data_oe <= 1'b0;
                              if (bit_cnt == 4'(PS2_FRAME_FALLS - 2)) state <= ACK;
                           end
                        end
                     end
                     ACK: begin
                        if (fall) begin
                           ack_ok  <= ~data_level;
                           bit_cnt <= bit_cnt + 4'd1;
                           state   <= WAIT_REL;
                        end
                     end
                     WAIT_REL: begin
                        if (clk_level && data_level) begin
                           tx_ready <= 1'b1;
                           done     <= 1'b1;
                           err      <= ACK_CHECK & ~ack_ok;
                           state    <= IDLE;
                        end
                     end
                     default: ;
                  endcase
               end
            end

            default: begin
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               tx_ready    <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a device clock BFM and a frame-level model.
// Expected err on a missing ack follows PS2_TX_ACK_CHECK_EN.
module tb_ps2_host_tx;

   localparam int INH  = 8;
   localparam int TMO  = 64;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bfm_clk = 1'b1;
   logic       bfm_data = 1'b1;
   logic       ps2_clk;
   logic       ps2_data;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       done;
   logic       err;

   int n_cmp = 0;
   int n_bad = 0;

   assign ps2_clk  = bfm_clk  & ~ps2_clk_oe;
   assign ps2_data = bfm_data & ~ps2_data_oe;

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .done        (done),
      .err         (err)
   );

   // Line values the device should see, index 0 = start bit, 10 = stop bit.
   function automatic logic [10:0] model_frame(input logic [7:0] b);
      logic [10:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = b[i];
      f[9]  = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
      f[10] = 1'b1;
      return f;
   endfunction

   function automatic logic model_err(input logic ack_line);
`ifdef PS2_TX_ACK_CHECK_EN
      return ack_line;
`else
      return 1'b0;
`endif
   endfunction

   // Device clock generator: samples the data line while clock is high, then drops clock.
   task automatic bfm_clock(input logic ack_line, input int n_falls, output logic [10:0] line_bits);
      line_bits = '1;
      for (int i = 0; i < n_falls; i++) begin
         bfm_clk = 1'b1;
         repeat (4) @(negedge clk);
         line_bits[i] = ps2_data;
         if (i == 10) bfm_data = ack_line;
         repeat (HALF - 4) @(negedge clk);
         bfm_clk = 1'b0;
         repeat (HALF) @(negedge clk);
      end
      if (n_falls == 11) begin
         bfm_clk  = 1'b1;
         bfm_data = 1'b1;
      end
   endtask

   task automatic send(input logic [7:0] b, input logic hold);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      if (!hold) tx_valid = 1'b0;
   endtask

   // Entered on the first negedge after the accepting edge.
   task automatic run_frame(input logic [7:0] exp_byte, input logic ack_line,
                            input logic next_valid, input logic [7:0] next_data, input string name);
      logic [10:0] bits;
      int cnt;
      n_cmp++;
      if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b100) begin
         n_bad++;
         $display("FAIL %s_accept: clk_oe/data_oe/ready got %b want 100", name, {ps2_clk_oe, ps2_data_oe, tx_ready});
      end
      cnt = 0;
      while (ps2_data_oe !== 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      n_cmp++;
      if (cnt !== INH) begin
         n_bad++;
         $display("FAIL %s_inhibit: cycles got %0d want %0d", name, cnt, INH);
      end
      @(negedge clk);
      n_cmp++;
      if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) begin
         n_bad++;
         $display("FAIL %s_start: clk_oe/data_oe got %b want 01", name, {ps2_clk_oe, ps2_data_oe});
      end
      bfm_clock(ack_line, 11, bits);
      n_cmp++;
      if (bits !== model_frame(exp_byte)) begin
         n_bad++;
         $display("FAIL %s_frame: line bits (stop..start) got %b want %b", name, bits, model_frame(exp_byte));
      end
      cnt = 0;
      while (done !== 1'b1 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      n_cmp++;
      if ({done, err, tx_ready, ps2_clk_oe, ps2_data_oe} !== {1'b1, model_err(ack_line), 3'b100}) begin
         n_bad++;
         $display("FAIL %s_done: done/err/ready/clk_oe/data_oe got %b want %b", name,
                  {done, err, tx_ready, ps2_clk_oe, ps2_data_oe}, {1'b1, model_err(ack_line), 3'b100});
      end
      tx_valid = next_valid;
      tx_data  = next_data;
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_pulse: done after one cycle got %b want 0", name, done);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({ps2_clk_oe, ps2_data_oe, tx_ready, done, err} !== 5'b00100) begin
         n_bad++;
         $display("FAIL reset_hold: outputs got %b want 00100", {ps2_clk_oe, ps2_data_oe, tx_ready, done, err});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({ps2_clk_oe, ps2_data_oe, tx_ready, done, err} !== 5'b00100) begin
         n_bad++;
         $display("FAIL reset_release: outputs got %b want 00100", {ps2_clk_oe, ps2_data_oe, tx_ready, done, err});
      end
   endtask

   task automatic test_set_led();
      send(8'hED, 1'b0);
      run_frame(8'hED, 1'b0, 1'b0, 8'h00, "set_led");
   endtask

   task automatic test_enable();
      send(8'hF4, 1'b0);
      run_frame(8'hF4, 1'b0, 1'b0, 8'h00, "enable");
   endtask

   task automatic test_nack();
      send(8'h00, 1'b0);
      run_frame(8'h00, 1'b1, 1'b0, 8'h00, "nack");
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic       a;
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom_range(0, 255));
         a = 1'($urandom_range(0, 1));
         send(b, 1'b0);
         run_frame(b, a, 1'b0, 8'h00, "random");
      end
   endtask

   task automatic test_timeout();
      int cnt;
      send(8'hF4, 1'b0);
      cnt = 0;
      while (ps2_clk_oe !== 1'b0 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      cnt = 0;
      while (done !== 1'b1 && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      n_cmp++;
      if (cnt !== TMO) begin
         n_bad++;
         $display("FAIL timeout_delay: cycles after start exit got %0d want %0d", cnt, TMO);
      end
      n_cmp++;
      if ({done, err, ps2_clk_oe, ps2_data_oe, tx_ready} !== 5'b11001) begin
         n_bad++;
         $display("FAIL timeout_state: done/err/clk_oe/data_oe/ready got %b want 11001",
                  {done, err, ps2_clk_oe, ps2_data_oe, tx_ready});
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [10:0] bits;
      int cnt;
      int dones;
      send(8'hF4, 1'b0);
      cnt = 0;
      while (ps2_clk_oe !== 1'b0 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      bfm_clock(1'b0, 4, bits);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({ps2_clk_oe, ps2_data_oe, tx_ready, done} !== 4'b0010) begin
         n_bad++;
         $display("FAIL reset_mid: clk_oe/data_oe/ready/done got %b want 0010", {ps2_clk_oe, ps2_data_oe, tx_ready, done});
      end
      rst     = 1'b0;
      bfm_clk = 1'b1;
      dones   = 0;
      repeat (100) begin
         @(negedge clk);
         if (done === 1'b1 || tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) dones++;
      end
      n_cmp++;
      if (dones !== 0) begin
         n_bad++;
         $display("FAIL reset_mid_quiet: cycles with done/busy got %0d want 0", dones);
      end
   endtask

   task automatic test_back_to_back();
      send(8'hED, 1'b1);
      tx_data = 8'h55;
      run_frame(8'hED, 1'b0, 1'b1, 8'hF4, "b2b_first");
      run_frame(8'hF4, 1'b0, 1'b0, 8'h00, "b2b_second");
      repeat (5) @(negedge clk);
      n_cmp++;
      if ({tx_ready, ps2_clk_oe} !== 2'b10) begin
         n_bad++;
         $display("FAIL b2b_idle: ready/clk_oe got %b want 10", {tx_ready, ps2_clk_oe});
      end
   endtask

   initial begin
      test_reset();
      test_set_led();
      test_enable();
      test_nack();
      test_random();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
